// File: rtl/loader_pkg.sv
// loader_pkg: definitions shared by the program loader and its word assembler.
//   loader_state_t   : load sequencer states
//   INST_W_DEFAULT   : core instruction width, shared with the decode stage
//   ACK_BYTE_DEFAULT : byte returned to the host after a good load
//   HDR_BYTES        : length of the word-count header in bytes
package loader_pkg;

  localparam int         INST_W_DEFAULT   = 32;
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAA;
  localparam int         HDR_BYTES        = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    ACK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into big-endian words.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : drops any partially assembled word
//   byte_in    : incoming byte
//   byte_valid : byte_in is accepted this cycle
//   word_out   : assembled word, valid together with word_valid
//   word_valid : one-cycle flag, high in the cycle the last byte of a word
//                is presented
// The outputs are combinational from the held bytes and the current byte,
// so the consumer can register the finished word on the same edge that
// accepts its last byte.
module word_assembler
  import loader_pkg::*;
#(
  parameter int WORD_W = INST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  // Holds the bytes already received for the current word, oldest on top.
  logic [WORD_W-9:0] shift_reg;
  logic [1:0]        byte_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (clear) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (byte_valid) begin
      shift_reg    <= {shift_reg[WORD_W-17:0], byte_in};
      // Wraps 3 -> 0 on the last byte of a word.
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  assign word_out   = {shift_reg, byte_in};
  assign word_valid = byte_valid && (byte_cnt_reg == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader that fills instruction memory from the UART.
// Receives a 4-byte big-endian word count N, then N big-endian instruction
// words, written to consecutive word addresses from 0. Afterwards the
// acknowledge byte is sent to the host and done is raised.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : one-cycle pulse that begins a load
//   rx_data, rx_valid    : received byte and its strobe
//   tx_data, tx_valid    : byte to transmit, held until tx_ready
//   tx_ready             : transmitter takes the byte
//   imem_we/addr/wdata   : instruction-memory write port (one-cycle pulse)
//   busy, done, error    : load in progress / finished / header rejected
//   word_count           : words written in the current load
// All outputs are registered.
module inst_loader
  import loader_pkg::*;
#(
  parameter int         INST_W   = INST_W_DEFAULT,
  parameter int         ADDR_W   = 15,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // Largest legal word count: the full memory, 2^ADDR_W words. One extra
  // bit so the comparison sees every header bit without truncation.
  localparam logic [INST_W:0] CAPACITY = (INST_W + 1)'(1) << ADDR_W;

  loader_state_t      state_reg, state_next;
  logic [INST_W-1:0]  hdr_reg, hdr_next;
  logic [ADDR_W:0]    word_count_reg, word_count_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic               tx_valid_reg, tx_valid_next;
  logic               imem_we_reg, imem_we_next;
  logic [ADDR_W-1:0]  imem_addr_reg, imem_addr_next;
  logic [INST_W-1:0]  imem_wdata_reg, imem_wdata_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               error_reg, error_next;

  logic               asm_clear;
  logic               asm_byte_valid;
  logic [INST_W-1:0]  asm_word;
  logic               asm_word_valid;
  logic [ADDR_W:0]    count_inc;

  // Bytes count only while a header or body is expected; anything arriving
  // in IDLE (including alongside start), ACK, DONE or ERR is dropped.
  assign asm_byte_valid = rx_valid && ((state_reg == HDR) || (state_reg == BODY));

  word_assembler #(
    .WORD_W(INST_W)
  ) u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_in    (rx_data),
    .byte_valid (asm_byte_valid),
    .word_out   (asm_word),
    .word_valid (asm_word_valid)
  );

  assign count_inc = word_count_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      hdr_reg        <= '0;
      word_count_reg <= '0;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hdr_reg        <= hdr_next;
      word_count_reg <= word_count_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hdr_next        = hdr_reg;
    word_count_next = word_count_reg;
    tx_data_next    = tx_data_reg;
    tx_valid_next   = tx_valid_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;
    asm_clear       = 1'b0;

    unique case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next      = HDR;
          hdr_next        = '0;
          word_count_next = '0;
          asm_clear       = 1'b1;
        end
      end

      HDR: begin
        if (asm_word_valid) begin
          hdr_next = asm_word;
          if (asm_word == '0) begin
            // Empty program: acknowledge straight away.
            state_next    = ACK;
            tx_valid_next = 1'b1;
            tx_data_next  = ACK_BYTE;
          end else if ({1'b0, asm_word} > CAPACITY) begin
            state_next = ERR;
          end else begin
            state_next = BODY;
          end
        end
      end

      BODY: begin
        if (asm_word_valid) begin
          imem_we_next    = 1'b1;
          imem_addr_next  = word_count_reg[ADDR_W-1:0];
          imem_wdata_next = asm_word;
          word_count_next = count_inc;
          // Leaving on the same edge as the last write keeps that write
          // ahead of done.
          if (INST_W'(count_inc) == hdr_reg) begin
            state_next    = ACK;
            tx_valid_next = 1'b1;
            tx_data_next  = ACK_BYTE;
          end
        end
      end

      ACK: begin
        if (tx_ready) begin
          state_next    = DONE;
          tx_valid_next = 1'b0;
          tx_data_next  = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Status flags follow the state being entered so they line up with
    // the registered state.
    busy_next  = (state_next == HDR) || (state_next == BODY) || (state_next == ACK);
    done_next  = (state_next == DONE);
    error_next = (state_next == ERR);
  end

  assign tx_data    = tx_data_reg;
  assign tx_valid   = tx_valid_reg;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign word_count = word_count_reg;

endmodule
